// File: rtl/mstore_pingpong.sv
// mstore_pingpong: double-buffered per-sample metadata store for the FFT datapath.
// Tags arrive one per input strobe and are grouped into frames of N. Each frame is
// replayed in natural or bit-reversed order while the next frame fills the other bank.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_nd      a new tag is present on in_m
//   in_m       tag to store
//   in_ready   write side can accept a tag (fewer than two full banks)
//   in_read    consumer takes out_m this cycle; advances the read pointer
//   out_m      tag at the current read position (show-ahead, combinational)
//   out_valid  at least one full bank is available to read
//   out_first  out_valid and read index == 0
//   out_last   out_valid and read index == N-1
//   error      sticky protocol-violation flag (overflow or underflow)
module mstore_pingpong #(
   parameter int unsigned N      = 8,
   parameter int unsigned MWIDTH = 1,
   parameter bit          BITREV = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_nd,
   input  logic [MWIDTH-1:0] in_m,
   output logic              in_ready,
   input  logic              in_read,
   output logic [MWIDTH-1:0] out_m,
   output logic              out_valid,
   output logic              out_first,
   output logic              out_last,
   output logic              error
);

   localparam int unsigned      LOG_N    = $clog2(N);
   localparam logic [LOG_N-1:0] LastAddr = LOG_N'(N - 1);

   // Storage: two banks, not reset.
   logic [MWIDTH-1:0] mem_q [2][N];

   logic             wr_bank_q, wr_bank_d;
   logic [LOG_N-1:0] wr_addr_q, wr_addr_d;
   logic             rd_bank_q, rd_bank_d;
   logic [LOG_N-1:0] rd_addr_q, rd_addr_d;
   logic [1:0]       full_cnt_q, full_cnt_d;
   logic             error_q, error_d;

   logic             wr_fire, wr_wrap;
   logic             rd_fire, rd_wrap;
   logic [LOG_N-1:0] ra;

   // Status derived from registered state only.
   assign in_ready  = (full_cnt_q != 2'd2);
   assign out_valid = (full_cnt_q != 2'd0);
   assign out_first = out_valid & (rd_addr_q == '0);
   assign out_last  = out_valid & (rd_addr_q == LastAddr);
   assign error     = error_q;

   assign wr_fire = in_nd & in_ready;
   assign wr_wrap = wr_fire & (wr_addr_q == LastAddr);
   assign rd_fire = in_read & out_valid;
   assign rd_wrap = rd_fire & (rd_addr_q == LastAddr);

   // Read address: optionally bit-reversed. Index 0 maps to 0 in either order.
   always_comb begin
      ra = rd_addr_q;
      if (BITREV) begin
         for (int i = 0; i < int'(LOG_N); i++) begin
            ra[i] = rd_addr_q[int'(LOG_N) - 1 - i];
         end
      end
   end

   // The read bank is always a full bank and the write bank never is, so the
   // same-cycle read and write never touch the same bank.
   assign out_m = mem_q[rd_bank_q][ra];

   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_addr_d = wr_addr_q;
      if (wr_fire) begin
         if (wr_wrap) begin
            wr_addr_d = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            wr_addr_d = wr_addr_q + LOG_N'(1);
         end
      end
   end

   always_comb begin
      rd_bank_d = rd_bank_q;
      rd_addr_d = rd_addr_q;
      if (rd_fire) begin
         if (rd_wrap) begin
            rd_addr_d = '0;
            rd_bank_d = ~rd_bank_q;
         end else begin
            rd_addr_d = rd_addr_q + LOG_N'(1);
         end
      end
   end

   // A frame completing on both sides in the same cycle leaves the count unchanged.
   always_comb begin
      full_cnt_d = full_cnt_q;
      case ({wr_wrap, rd_wrap})
         2'b10:   full_cnt_d = full_cnt_q + 2'd1;
         2'b01:   full_cnt_d = full_cnt_q - 2'd1;
         default: full_cnt_d = full_cnt_q;
      endcase
   end

   // Overflow and underflow both latch the flag; only reset clears it.
   always_comb begin
      error_d = error_q | (in_nd & ~in_ready) | (in_read & ~out_valid);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q  <= 1'b0;
         wr_addr_q  <= '0;
         rd_bank_q  <= 1'b0;
         rd_addr_q  <= '0;
         full_cnt_q <= 2'd0;
         error_q    <= 1'b0;
      end else begin
         wr_bank_q  <= wr_bank_d;
         wr_addr_q  <= wr_addr_d;
         rd_bank_q  <= rd_bank_d;
         rd_addr_q  <= rd_addr_d;
         full_cnt_q <= full_cnt_d;
         error_q    <= error_d;
      end
   end

   // Dropped writes (overflow) never reach the array.
   always_ff @(posedge clk) begin
      if (wr_fire && !rst) begin
         mem_q[wr_bank_q][wr_addr_q] <= in_m;
      end
   end

endmodule

// File: tb/tb_mstore_pingpong.sv
// Bench for mstore_pingpong: two instances (natural and bit-reversed order) share the
// same stimulus and are compared against a frame-queue reference model.
module tb_mstore_pingpong;

   localparam int N = 8;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_nd = 1'b0;
   logic [W-1:0] in_m = '0;
   logic         in_read = 1'b0;

   logic         in_ready0, out_valid0, out_first0, out_last0, error0;
   logic [W-1:0] out_m0;
   logic         in_ready1, out_valid1, out_first1, out_last1, error1;
   logic [W-1:0] out_m1;

   int checks = 0;
   int errors = 0;

   // Reference model: completed frames concatenated, the partial frame, read index, error.
   logic [W-1:0] full_q[$];
   logic [W-1:0] part_q[$];
   int           rd_idx = 0;
   logic         err_m = 1'b0;

   always #5 clk = ~clk;

   mstore_pingpong #(.N(N), .MWIDTH(W), .BITREV(1'b0)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .in_nd    (in_nd),
      .in_m     (in_m),
      .in_ready (in_ready0),
      .in_read  (in_read),
      .out_m    (out_m0),
      .out_valid(out_valid0),
      .out_first(out_first0),
      .out_last (out_last0),
      .error    (error0)
   );

   mstore_pingpong #(.N(N), .MWIDTH(W), .BITREV(1'b1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .in_nd    (in_nd),
      .in_m     (in_m),
      .in_ready (in_ready1),
      .in_read  (in_read),
      .out_m    (out_m1),
      .out_valid(out_valid1),
      .out_first(out_first1),
      .out_last (out_last1),
      .error    (error1)
   );

   // Reverse the bits of v across log2(N) positions, arithmetically.
   function automatic int rev(input int v);
      int r = 0;
      for (int b = 1; b < N; b *= 2) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_nd = 1'b0;
      in_read = 1'b0;
      @(posedge clk);
      full_q.delete();
      part_q.delete();
      rd_idx = 0;
      err_m = 1'b0;
      #1 rst = 1'b0;
   endtask

   // One clock: drive inputs and check outputs at the falling edge, then advance the model.
   task automatic cycle(input logic nd, input logic [W-1:0] m, input logic rd);
      int   nfull;
      logic wr_ok, rd_ok;
      @(negedge clk);
      in_nd = nd;
      in_m = m;
      in_read = rd;
      nfull = full_q.size() / N;
      check("in_ready", 32'(in_ready0), 32'(nfull < 2));
      check("out_valid", 32'(out_valid0), 32'(nfull > 0));
      check("error", 32'(error0), 32'(err_m));
      check("out_valid_rev", 32'(out_valid1), 32'(nfull > 0));
      if (nfull > 0) begin
         check("out_m_nat", 32'(out_m0), 32'(full_q[rd_idx]));
         check("out_m_rev", 32'(out_m1), 32'(full_q[rev(rd_idx)]));
         check("out_first", 32'(out_first0), 32'(rd_idx == 0));
         check("out_last", 32'(out_last0), 32'(rd_idx == N - 1));
      end else begin
         check("out_first_idle", 32'(out_first0), 32'(0));
         check("out_last_idle", 32'(out_last0), 32'(0));
      end
      @(posedge clk);
      wr_ok = nd && (nfull < 2);
      rd_ok = rd && (nfull > 0);
      if ((nd && !wr_ok) || (rd && !rd_ok)) err_m = 1'b1;
      if (rd_ok) begin
         rd_idx++;
         if (rd_idx == N) begin
            rd_idx = 0;
            repeat (N) void'(full_q.pop_front());
         end
      end
      if (wr_ok) begin
         part_q.push_back(m);
         if (part_q.size() == N) begin
            foreach (part_q[i]) full_q.push_back(part_q[i]);
            part_q.delete();
         end
      end
   endtask

   initial begin
      // Reset state.
      do_reset();
      cycle(1'b0, '0, 1'b0);

      // One frame 0..7, then eight reads; valid drops afterwards.
      for (int i = 0; i < N; i++) cycle(1'b1, W'(i), 1'b0);
      for (int i = 0; i < N; i++) cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);

      // Three frames streamed, reads start eight cycles after the first write.
      do_reset();
      for (int k = 0; k < 3 * N + N; k++) begin
         cycle(k < 3 * N, W'(k), k >= N);
      end
      cycle(1'b0, '0, 1'b0);

      // Fill both banks, overflow once, then drain.
      do_reset();
      for (int i = 0; i < 2 * N; i++) cycle(1'b1, W'(i), 1'b0);
      cycle(1'b1, 4'hA, 1'b0);
      cycle(1'b0, '0, 1'b0);
      for (int i = 0; i < 2 * N; i++) cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);

      // Underflow from reset, then a normal frame.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
      for (int i = 0; i < N; i++) cycle(1'b1, W'($urandom), 1'b0);
      for (int i = 0; i < N; i++) cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);

      // Partial frame discarded by reset.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, W'(i + 3), 1'b0);
      do_reset();
      for (int i = 0; i < N; i++) cycle(1'b1, W'(10 + i), 1'b0);
      for (int i = 0; i < N; i++) cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);

      // Random traffic, including simultaneous wraps, overflows and underflows.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 55);
      end
      cycle(1'b0, '0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
